// File: rtl/result_collector_if.sv
// Bundle of the result strobe, consumer read port and status/statistics outputs of result_collector.
// The slave modport is the collector's view; the master modport is the producer/consumer side.
interface result_collector_if #(
  parameter int DEPTH = 8,
  parameter int SUM_W = 20
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              done_sig;
  logic [15:0]       product;
  logic              clear;
  logic              rd_req;
  logic [15:0]       rd_data;
  logic              rd_valid;
  logic              empty_out;
  logic              full_out;
  logic [CW-1:0]     count;
  logic [SUM_W-1:0]  acc_sum;
  logic [7:0]        drop_cnt;
  logic              overflow;

  modport slave (
    input  done_sig, product, clear, rd_req,
    output rd_data, rd_valid, empty_out, full_out, count, acc_sum, drop_cnt, overflow
  );

  modport master (
    output done_sig, product, clear, rd_req,
    input  rd_data, rd_valid, empty_out, full_out, count, acc_sum, drop_cnt, overflow
  );
endinterface

// File: rtl/result_collector.sv
// Result buffer: FIFO of signed 16-bit results with a saturating running sum,
// drop statistics on full, and a registered one-cycle-latency read port.
module result_collector #(
  parameter int DEPTH = 8,
  parameter int SUM_W = 20
) (
  input logic               clk,
  input logic               rst_n,
  result_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

  typedef enum logic {S_IDLE, S_RESP} state_t;

  logic [15:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic [SUM_W-1:0] r_acc;
  logic [7:0]       r_drop_cnt;
  logic             r_overflow;
  state_t           r_state;
  logic             r_rd_valid;
  logic [15:0]      r_rd_data;

  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_drop;
  logic [CW-1:0]    w_count_next;
  logic [SUM_W:0]   w_sum_wide;
  logic [SUM_W-1:0] w_sum_sat;
  logic [15:0]      w_rd_word;

  // clear discards any same-cycle traffic, so it also masks the drop path
  assign w_rd_acc = bus.rd_req & ~r_empty & ~bus.clear;
  assign w_wr_acc = bus.done_sig & (~r_full | w_rd_acc) & ~bus.clear;
  assign w_drop   = bus.done_sig & r_full & ~w_rd_acc & ~bus.clear;

  always_comb begin
    w_count_next = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_wr_acc && w_rd_acc) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // One guard bit: the sum overflowed when the top two bits disagree
  assign w_sum_wide = {r_acc[SUM_W-1], r_acc} + {{(SUM_W+1-16){bus.product[15]}}, bus.product};

  always_comb begin
    w_sum_sat = w_sum_wide[SUM_W-1:0];
    if (w_sum_wide[SUM_W] != w_sum_wide[SUM_W-1]) begin
      w_sum_sat = w_sum_wide[SUM_W] ? SUM_MIN : SUM_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.product;
    end
  end

  assign w_rd_word = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_acc      <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (bus.clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_acc      <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_acc    <= w_sum_sat;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(DEPTH));
      r_empty <= (w_count_next == '0);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  // Read-response FSM; rd_data holds its last value when no read is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 16'h0000;
    end else if (bus.clear) begin
      r_state    <= S_IDLE;
      r_rd_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rd_acc) begin
            r_state    <= S_RESP;
            r_rd_valid <= 1'b1;
            r_rd_data  <= w_rd_word;
          end else begin
            r_rd_valid <= 1'b0;
          end
        end
        S_RESP: begin
          if (w_rd_acc) begin
            r_state    <= S_RESP;
            r_rd_valid <= 1'b1;
            r_rd_data  <= w_rd_word;
          end else begin
            r_state    <= S_IDLE;
            r_rd_valid <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_rd_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.empty_out = r_empty;
  assign bus.full_out  = r_full;
  assign bus.count     = r_count;
  assign bus.acc_sum   = r_acc;
  assign bus.drop_cnt  = r_drop_cnt;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: reads push expected words into a scoreboard
// queue that a negedge monitor drains whenever rd_valid is presented.
module tb_result_collector;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [15:0] exp_q[$];

  result_collector_if #(.DEPTH(8), .SUM_W(20)) bus ();

  result_collector #(.DEPTH(8), .SUM_W(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input logic d, input logic [15:0] p, input logic r, input logic c);
    bus.done_sig = d;
    bus.product  = p;
    bus.rd_req   = r;
    bus.clear    = c;
    @(posedge clk);
    #1;
    bus.done_sig = 1'b0;
    bus.rd_req   = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic wr(input logic [15:0] v);
    step(1'b1, v, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [15:0] e);
    exp_q.push_back(e);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_empty"}, int'(bus.empty_out), 1);
    chk({tag, "_full"}, int'(bus.full_out), 0);
    chk({tag, "_count"}, int'(bus.count), 0);
    chk({tag, "_acc"}, int'(bus.acc_sum), 0);
    chk({tag, "_drop"}, int'(bus.drop_cnt), 0);
    chk({tag, "_ovf"}, int'(bus.overflow), 0);
    chk({tag, "_rdvalid"}, int'(bus.rd_valid), 0);
    chk({tag, "_rddata"}, int'(bus.rd_data), 0);
  endtask

  function automatic int acc_int();
    return int'($signed(bus.acc_sum));
  endfunction

  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (rst_n && bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got 0x%04h expected no read response", bus.rd_data);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", int'(bus.rd_data), int'(e));
        $display("read 0x%04h expected 0x%04h", bus.rd_data, e);
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    bus.done_sig = 1'b0;
    bus.product  = 16'h0000;
    bus.rd_req   = 1'b0;
    bus.clear    = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    step(1'b0, 16'h0000, 1'b0, 1'b0);

    // three writes then three reads
    wr(16'h0016);
    wr(16'h000B);
    wr(16'hFFFA);
    chk("t1_count", int'(bus.count), 3);
    chk("t1_acc", acc_int(), 27);
    rd(16'h0016);
    rd(16'h000B);
    rd(16'hFFFA);
    chk("t1_empty", int'(bus.empty_out), 1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("t1_empty_rd_valid", int'(bus.rd_valid), 0);
    chk("t1_empty_rd_hold", int'(bus.rd_data), 16'hFFFA);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // nine writes into an eight-deep buffer
    for (int i = 0; i < 9; i++) begin
      wr(16'h0100 + 16'(i));
      if (i == 7) chk("t2_full_after8", int'(bus.full_out), 1);
    end
    chk("t2_count", int'(bus.count), 8);
    chk("t2_drop", int'(bus.drop_cnt), 1);
    chk("t2_ovf", int'(bus.overflow), 1);
    for (int i = 0; i < 8; i++) rd(16'h0100 + 16'(i));
    chk("t2_empty", int'(bus.empty_out), 1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // write and read together while full
    for (int i = 0; i < 8; i++) wr(16'h0200 + 16'(i));
    exp_q.push_back(16'h0200);
    step(1'b1, 16'h02AA, 1'b1, 1'b0);
    chk("t3_count", int'(bus.count), 8);
    chk("t3_drop", int'(bus.drop_cnt), 0);
    chk("t3_full", int'(bus.full_out), 1);
    for (int i = 1; i < 8; i++) rd(16'h0200 + 16'(i));
    rd(16'h02AA);
    chk("t3_empty", int'(bus.empty_out), 1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // positive saturation
    wr(16'h7FFF);
    for (int i = 1; i < 17; i++) begin
      exp_q.push_back(16'h7FFF);
      step(1'b1, 16'h7FFF, 1'b1, 1'b0);
      if (i == 15) chk("t4_acc_16", acc_int(), 524272);
    end
    chk("t4_acc_sat", acc_int(), 524287);
    exp_q.push_back(16'h7FFF);
    step(1'b1, 16'h8000, 1'b1, 1'b0);
    chk("t4_acc_back", acc_int(), 491519);
    rd(16'h8000);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // negative saturation
    wr(16'h8000);
    for (int i = 1; i < 17; i++) begin
      exp_q.push_back(16'h8000);
      step(1'b1, 16'h8000, 1'b1, 1'b0);
      if (i == 15) chk("t4n_acc_16", acc_int(), -524288);
    end
    chk("t4n_acc_sat", acc_int(), -524288);
    exp_q.push_back(16'h8000);
    step(1'b1, 16'h0001, 1'b1, 1'b0);
    chk("t4n_acc_back", acc_int(), -524287);
    rd(16'h0001);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // clear against a coincident write and read
    wr(16'h0011);
    wr(16'h0022);
    wr(16'h0033);
    step(1'b1, 16'h0044, 1'b1, 1'b1);
    chk("t5_count", int'(bus.count), 0);
    chk("t5_empty", int'(bus.empty_out), 1);
    chk("t5_acc", acc_int(), 0);
    chk("t5_rd_valid", int'(bus.rd_valid), 0);
    chk("t5_drop", int'(bus.drop_cnt), 0);

    // drop counter saturation
    for (int i = 0; i < 8; i++) wr(16'h0300 + 16'(i));
    for (int i = 0; i < 260; i++) wr(16'h0EEE);
    chk("t6_drop_sat", int'(bus.drop_cnt), 255);
    chk("t6_ovf", int'(bus.overflow), 1);
    chk("t6_count", int'(bus.count), 8);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("t6_clr_drop", int'(bus.drop_cnt), 0);
    chk("t6_clr_ovf", int'(bus.overflow), 0);

    // asynchronous reset with data in flight
    for (int i = 0; i < 5; i++) wr(16'h0400 + 16'(i));
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("t7_rd_valid_pre", int'(bus.rd_valid), 1);
    rst_n = 1'b0;
    #1;
    check_reset_values("t7_async");
    #1;
    rst_n = 1'b1;
    wr(16'h0ABC);
    chk("t7_count_after", int'(bus.count), 1);
    rd(16'h0ABC);
    chk("t7_empty_after", int'(bus.empty_out), 1);

    repeat (3) step(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
